// File: rtl/booth_div.sv
// Sequential radix-2 restoring divider (signed/unsigned), companion to the Booth multiplier.
// Optional macro BOOTH_DIV_EARLY_OUT_EN skips CALC for trivial divisors/dividends.
module booth_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  localparam int unsigned   CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]  CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             accept;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH+1:0] diff;
  logic             early;

  // The done cycle still blocks a new start, so a held start is taken one cycle later.
  assign accept  = (state_q == StIdle) && !done_q && start_i;
  assign dvd_neg = signed_op_i & dividend_i[WIDTH-1];
  assign dvs_neg = signed_op_i & divisor_i[WIDTH-1];
  assign dvd_abs = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_abs = dvs_neg ? -divisor_i : divisor_i;
  assign a_sh    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  // One extra bit: a shifted unsigned remainder can reach 2^WIDTH.
  assign diff    = {1'b0, a_sh} - {2'b00, m_q};

`ifdef BOOTH_DIV_EARLY_OUT_EN
  assign early = (divisor_i == '0) || (divisor_i == WIDTH'(1)) ||
                 (signed_op_i && (divisor_i == '1)) || (dividend_i == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    signed_d = signed_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          signed_d = signed_op_i;
          dvd_d    = dividend_i;
          dvs_d    = divisor_i;
          neg_q_d  = dvd_neg ^ dvs_neg;
          neg_r_d  = dvd_neg;
          q_d      = dvd_abs;
          m_d      = dvs_abs;
          a_d      = '0;
          cnt_d    = CntInit;
          state_d  = early ? StFix : StCalc;
        end
      end
      StCalc: begin
        a_d   = diff[WIDTH+1] ? a_sh : diff[WIDTH:0];
        q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH+1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntOne) state_d = StFix;
      end
      StFix: begin
        quo_d  = neg_q_q ? -q_q : q_q;
        rem_d  = neg_r_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        dbz_d  = 1'b0;
        ovf_d  = 1'b0;
        if (dvs_q == '0) begin
          quo_d = '1;
          rem_d = dvd_q;
          dbz_d = 1'b1;
        end else if (signed_q && (dvd_q == MinVal) && (dvs_q == '1)) begin
          quo_d = MinVal;
          rem_d = '0;
          ovf_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      signed_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      signed_q <= signed_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy_o        = (state_q != StIdle) || done_q;
  assign done_o        = done_q;
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;
  assign overflow_o    = ovf_q;

endmodule
